opcode_encoder_issuer: RTL and testbench

- Transmit-side counterpart of the casex instruction-type decoder.
- Accepts instruction-type requests (2-bit type plus 2-bit argument) over a valid/ready handshake and encodes each one into the 4-bit opcode space the decoder matches.
- Buffers encoded opcodes in a small FIFO and issues them downstream over a second valid/ready handshake.
- Sits between the instruction sequencer and the decode stage; a decoder fed from out_opcode returns the original in_type.

---
 rtl/opcode_encoder_issuer.sv | 119 +++++++++++
 tb/tb_opcode_encoder_issuer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/opcode_encoder_issuer.sv
// Encodes instruction-type requests into 4-bit opcodes and issues them through a small FWFT FIFO.
// Optional macro OPCODE_PARITY_EN adds a per-entry even-parity bit and the out_parity port.
`timescale 1ns / 1ps
module opcode_encoder_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic [1:0]       in_arg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic             err_pulse,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef OPCODE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] Full = DEPTH[PtrW:0];
`ifdef OPCODE_PARITY_EN
  localparam int unsigned EntW = 5;
`else
  localparam int unsigned EntW = 4;
`endif

  logic [EntW-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic            w_accept;
  logic            w_unknown;
  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_enc;
  logic [EntW-1:0] w_entry;
  logic [EntW-1:0] w_head;

  always_comb begin
    w_enc = 4'b0000;
    unique case (in_type)
      2'b01:   w_enc = {2'b10, in_arg};
      2'b10:   w_enc = {3'b010, in_arg[0]};
      2'b11:   w_enc = 4'b0011;
      default: w_enc = 4'b0000;
    endcase
  end

`ifdef OPCODE_PARITY_EN
  assign w_entry = {^w_enc, w_enc};
`else
  assign w_entry = w_enc;
`endif

  // in_ready depends only on occupancy, so a same-cycle pop never frees a full FIFO
  assign in_ready  = (r_count != Full);
  assign w_accept  = in_valid && in_ready;
  assign w_unknown = (in_type == 2'b00);
  assign w_push    = w_accept && !w_unknown;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_opcode = w_head[3:0];
  assign err_pulse  = r_err_pulse;
  assign issue_cnt  = r_issue_cnt;
  assign err_cnt    = r_err_cnt;
`ifdef OPCODE_PARITY_EN
  assign out_parity = w_head[4];
`endif

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_pulse <= 1'b0;
      r_issue_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept && w_unknown;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_accept && w_unknown && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_opcode_encoder_issuer.sv
// Directed self-checking bench for opcode_encoder_issuer (DEPTH=4, CNT_W=8).
`timescale 1ns / 1ps
module tb_opcode_encoder_issuer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_type;
  logic [1:0] in_arg;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_opcode;
  logic       err_pulse;
  logic [7:0] issue_cnt;
  logic [7:0] err_cnt;
`ifdef OPCODE_PARITY_EN
  logic       out_parity;
`endif

  int n_tests;
  int n_fail;

  opcode_encoder_issuer #(
    .DEPTH(4),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_arg     (in_arg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .err_pulse  (err_pulse),
    .issue_cnt  (issue_cnt),
    .err_cnt    (err_cnt)
`ifdef OPCODE_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_type   = 2'b00;
    in_arg    = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_opcode", 32'(out_opcode), 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Three types in order
    in_valid = 1'b1; in_type = 2'b01; in_arg = 2'b11;
    chk("seq_valid_before", 32'(out_valid), 32'd0);
    tick();
    chk("seq_valid_after1", 32'(out_valid), 32'd1);
    chk("seq_head_a", 32'(out_opcode), 32'hB);
    in_type = 2'b10; in_arg = 2'b01;
    tick();
    in_type = 2'b11; in_arg = 2'b00;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("seq_pop_a", 32'(out_opcode), 32'hB);
    tick();
    chk("seq_pop_b", 32'(out_opcode), 32'h5);
    tick();
    chk("seq_pop_c", 32'(out_opcode), 32'h3);
    tick();
    chk("seq_empty_valid", 32'(out_valid), 32'd0);
    chk("seq_empty_opcode", 32'(out_opcode), 32'h0);
    chk("seq_issue_cnt", 32'(issue_cnt), 32'd3);

    // Back-pressure: five TYPE_C with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 2'b11; in_arg = 2'b10;
    tick();
    tick();
    tick();
    chk("full_ready_at3", 32'(in_ready), 32'd1);
    tick();
    chk("full_ready_at4", 32'(in_ready), 32'd0);
    tick();
    chk("full_stall_ready", 32'(in_ready), 32'd0);
    chk("full_stall_issue", 32'(issue_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("full_pop_reopens", 32'(in_ready), 32'd1);
    chk("full_issue_4", 32'(issue_cnt), 32'd4);
    tick();
    in_valid = 1'b0;
    chk("full_issue_5", 32'(issue_cnt), 32'd5);
    chk("full_head_c", 32'(out_opcode), 32'h3);
    tick();
    tick();
    chk("full_left_one", 32'(out_valid), 32'd1);
    chk("full_last_c", 32'(out_opcode), 32'h3);
    tick();
    chk("full_drained", 32'(out_valid), 32'd0);
    chk("full_issue_8", 32'(issue_cnt), 32'd8);

    // TYPE_UNKNOWN rejected
    in_valid = 1'b1; in_type = 2'b00; in_arg = 2'b00;
    chk("unk_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("unk_err_pulse", 32'(err_pulse), 32'd1);
    chk("unk_err_cnt", 32'(err_cnt), 32'd1);
    chk("unk_not_queued", 32'(out_valid), 32'd0);
    tick();
    chk("unk_pulse_clear", 32'(err_pulse), 32'd0);
    chk("unk_err_cnt_hold", 32'(err_cnt), 32'd1);
    chk("unk_still_empty", 32'(out_valid), 32'd0);

    // Steady two-entry stream across pointer wrap
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 2'b01; in_arg = 2'b00;
    tick();
    in_arg = 2'b01;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_arg = 2'((i + 2) % 4);
      chk($sformatf("wrap_head_%0d", i), 32'(out_opcode), 32'(8 + (i % 4)));
      tick();
      chk($sformatf("wrap_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    chk("wrap_issue_cnt", 32'(issue_cnt), 32'd16);
    chk("wrap_tail_head", 32'(out_opcode), 32'h8);

    // Mid-operation reset with three queued entries
    out_ready = 1'b0;
    in_type = 2'b11;
    tick();
    rst = 1'b1; in_type = 2'b01; in_arg = 2'b11;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_opcode", 32'(out_opcode), 32'h0);
    chk("mrst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("mrst_not_captured", 32'(out_valid), 32'd0);

`ifdef OPCODE_PARITY_EN
    chk("par_empty", 32'(out_parity), 32'd0);
    in_valid = 1'b1; in_type = 2'b01; in_arg = 2'b01;
    tick();
    in_type = 2'b10; in_arg = 2'b11;
    tick();
    in_type = 2'b01; in_arg = 2'b00;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("par_op_1001", 32'(out_opcode), 32'h9);
    chk("par_1001", 32'(out_parity), 32'd0);
    tick();
    chk("par_op_0101", 32'(out_opcode), 32'h5);
    chk("par_0101", 32'(out_parity), 32'd0);
    tick();
    chk("par_op_1000", 32'(out_opcode), 32'h8);
    chk("par_1000", 32'(out_parity), 32'd1);
    tick();
    chk("par_empty_end", 32'(out_parity), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
